// File: rtl/requant_sched_pkg.sv
// Shared types, constants and arithmetic helpers for the INT32->INT8 requantize
// sequencer and its requantize primitive.
package dpu_requant_pkg;

    typedef enum logic [1:0] {
        RQ_IDLE  = 2'd0,
        RQ_RUN   = 2'd1,
        RQ_DRAIN = 2'd2,
        RQ_FIN   = 2'd3
    } rq_state_e;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [7:0] PAD_BYTE       = 8'h00;
    // 32-bit signed accumulator times 17-bit zero-extended scale
    localparam int         PROD_W         = 49;

    function automatic logic [7:0] sat_int8(input logic signed [PROD_W-1:0] v);
        logic [7:0] r;
        if (v > 49'sd127) begin
            r = 8'h7f;
        end else if (v < -49'sd128) begin
            r = 8'h80;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    function automatic logic [31:0] pad_word(input logic [23:0] hold, input logic [1:0] fill);
        logic [31:0] w;
        case (fill)
            2'd1:    w = {PAD_BYTE, PAD_BYTE, PAD_BYTE, hold[7:0]};
            2'd2:    w = {PAD_BYTE, PAD_BYTE, hold[15:0]};
            2'd3:    w = {PAD_BYTE, hold};
            default: w = {PAD_BYTE, PAD_BYTE, PAD_BYTE, PAD_BYTE};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/requant_sched_if.sv
// Accumulator-in / packed-word-out stream bundle of the requantize sequencer.
// The sequencer takes the master modport; the environment takes the slave side.
interface requant_sched_if;
    logic        acc_valid;
    logic [31:0] acc_data;
    logic        acc_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;

    modport master (
        input  acc_valid, acc_data, out_ready,
        output acc_ready, out_valid, out_data, out_last
    );

    modport slave (
        output acc_valid, acc_data, out_ready,
        input  acc_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/requant_sched_requantize.sv
// requantize primitive: captures one accumulator/scale pair per start and presents
// the floored, saturated INT8 result with done during the following cycle.
module requantize
    import dpu_requant_pkg::*;
#(
    parameter int SCALE_Q = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] acc,
    input  logic [15:0] scale,
    output logic        done,
    output logic [7:0]  q
);

    logic [31:0]              acc_r;
    logic [15:0]              scale_r;
    logic                     done_r;
    logic signed [PROD_W-1:0] acc_ext_s;
    logic signed [PROD_W-1:0] scl_ext_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [PROD_W-1:0] shift_s;

    // operand capture and result strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= 32'd0;
            scale_r <= 16'd0;
            done_r  <= 1'b0;
        end else begin
            done_r <= start;
            if (start) begin
                acc_r   <= acc;
                scale_r <= scale;
            end
        end
    end

    // signed multiply, arithmetic shift (floor), saturate
    always_comb begin
        acc_ext_s = {{(PROD_W-32){acc_r[31]}}, acc_r};
        scl_ext_s = {{(PROD_W-16){1'b0}}, scale_r};
        prod_s    = acc_ext_s * scl_ext_s;
        shift_s   = prod_s >>> SCALE_Q;
        q         = sat_int8(shift_s);
    end

    assign done = done_r;

endmodule

// File: rtl/requant_sched.sv
// requant_sched: sequences INT32 accumulators through one requantize instance using a
// per-channel scale table and packs the INT8 results four per word.
module requant_sched
    import dpu_requant_pkg::*;
#(
    parameter int MAX_CH  = 64,
    parameter int SCALE_Q = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [$clog2(MAX_CH)-1:0]  cfg_addr,
    input  logic [15:0]                cfg_scale,
    input  logic                       start,
    input  logic [$clog2(MAX_CH+1)-1:0] num_ch,
    input  logic [15:0]                num_pix,
    requant_sched_if.master            bus,
    output logic                       busy,
    output logic                       done
);

    localparam int               CH_W    = $clog2(MAX_CH);
    localparam int               NCH_W   = $clog2(MAX_CH+1);
    localparam logic [NCH_W-1:0] NCH_ONE = NCH_W'(1);
    localparam logic [1:0]       FILL_LAST = 2'(BYTES_PER_WORD-1);

    rq_state_e         state_r, state_s;
    logic [15:0]       tab_r [MAX_CH];
    logic [NCH_W-1:0]  num_ch_r;
    logic [CH_W-1:0]   ch_r;
    logic [31:0]       remaining_r;
    logic [31:0]       total_s;
    logic              acc_ready_s, acc_fire_s, last_acc_s, ch_wrap_s;
    logic              last_tag_r;
    logic              rq_done_s;
    logic [7:0]        rq_q_s;
    logic [1:0]        fill_r;
    logic [23:0]       hold_r, hold_nxt_s;
    logic              flush_r, flush_fire_s, word_load_s;
    logic              out_valid_r, out_last_r;
    logic [31:0]       out_data_r;
    logic              busy_s, done_s;

    assign total_s     = 32'(num_ch) * 32'(num_pix);
    // the output slot must be free (or emptying) so a word produced next cycle has room
    assign acc_ready_s = (state_r == RQ_RUN) && (remaining_r != 32'd0) &&
                         (!out_valid_r || bus.out_ready);
    assign acc_fire_s  = acc_ready_s && bus.acc_valid;
    assign last_acc_s  = acc_fire_s && (remaining_r == 32'd1);
    assign ch_wrap_s   = ((NCH_W'(ch_r) + NCH_ONE) == num_ch_r);

    // scale table, writable only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_CH; i++) begin
                tab_r[i] <= 16'h0000;
            end
        end else if (cfg_we && (state_r == RQ_IDLE)) begin
            tab_r[cfg_addr] <= cfg_scale;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RQ_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            RQ_IDLE: begin
                if (start) begin
                    state_s = (total_s == 32'd0) ? RQ_FIN : RQ_RUN;
                end else begin
                    state_s = RQ_IDLE;
                end
            end
            RQ_RUN: begin
                if (last_acc_s) begin
                    state_s = RQ_DRAIN;
                end else begin
                    state_s = RQ_RUN;
                end
            end
            RQ_DRAIN: begin
                if (out_valid_r && bus.out_ready && out_last_r) begin
                    state_s = RQ_FIN;
                end else begin
                    state_s = RQ_DRAIN;
                end
            end
            RQ_FIN:  state_s = RQ_IDLE;
            default: state_s = RQ_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            RQ_IDLE:  busy_s = 1'b0;
            RQ_RUN:   busy_s = 1'b1;
            RQ_DRAIN: busy_s = 1'b1;
            RQ_FIN: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: busy_s = 1'b0;
        endcase
    end

    // job counters: channel index and accumulators still to accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_ch_r    <= '0;
            ch_r        <= '0;
            remaining_r <= 32'd0;
            last_tag_r  <= 1'b0;
        end else begin
            last_tag_r <= last_acc_s;
            if ((state_r == RQ_IDLE) && start) begin
                num_ch_r    <= num_ch;
                remaining_r <= total_s;
                ch_r        <= '0;
            end else if (acc_fire_s) begin
                remaining_r <= remaining_r - 32'd1;
                ch_r        <= ch_wrap_s ? '0 : ch_r + CH_W'(1);
            end
        end
    end

    requantize #(
        .SCALE_Q (SCALE_Q)
    ) u_requantize (
        .clk   (clk),
        .rst_n (rst_n),
        .start (acc_fire_s),
        .acc   (bus.acc_data),
        .scale (tab_r[ch_r]),
        .done  (rq_done_s),
        .q     (rq_q_s)
    );

    assign word_load_s  = rq_done_s && (fill_r == FILL_LAST);
    assign flush_fire_s = flush_r && (state_r == RQ_DRAIN) && (!out_valid_r || bus.out_ready);

    // place the incoming byte at the current fill position
    always_comb begin
        hold_nxt_s = hold_r;
        case (fill_r)
            2'd0:    hold_nxt_s[7:0]   = rq_q_s;
            2'd1:    hold_nxt_s[15:8]  = rq_q_s;
            2'd2:    hold_nxt_s[23:16] = rq_q_s;
            default: hold_nxt_s        = hold_r;
        endcase
    end

    // byte packer: fill counter, holding register, pending partial-word flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_r  <= 2'd0;
            hold_r  <= 24'd0;
            flush_r <= 1'b0;
        end else if (word_load_s) begin
            fill_r  <= 2'd0;
            hold_r  <= 24'd0;
            flush_r <= 1'b0;
        end else if (rq_done_s) begin
            fill_r  <= fill_r + 2'd1;
            hold_r  <= hold_nxt_s;
            flush_r <= last_tag_r;
        end else if (flush_fire_s) begin
            fill_r  <= 2'd0;
            hold_r  <= 24'd0;
            flush_r <= 1'b0;
        end
    end

    // output word register; a load may coincide with the downstream pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 32'd0;
            out_last_r  <= 1'b0;
        end else if (word_load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= {rq_q_s, hold_r};
            out_last_r  <= last_tag_r;
        end else if (flush_fire_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= pad_word(hold_r, fill_r);
            out_last_r  <= 1'b1;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

    assign bus.acc_ready = acc_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;
    assign busy          = busy_s;
    assign done          = done_s;

endmodule

// File: tb/tb_requant_sched.sv
// Randomized scoreboard bench for requant_sched: a floor-division reference model
// predicts packed words; an independent monitor pops and compares on each handshake.
module tb_requant_sched;

    localparam int MAX_CH  = 64;
    localparam int SCALE_Q = 16;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [5:0]  cfg_addr = 6'd0;
    logic [15:0] cfg_scale = 16'd0;
    logic        start = 1'b0;
    logic [6:0]  num_ch = 7'd0;
    logic [15:0] num_pix = 16'd0;
    logic        busy, done;

    requant_sched_if bus ();

    requant_sched #(.MAX_CH(MAX_CH), .SCALE_Q(SCALE_Q)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_scale (cfg_scale),
        .start     (start),
        .num_ch    (num_ch),
        .num_pix   (num_pix),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    word_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned mdl_tab[MAX_CH];
    int          ready_mode = 0;
    int          bp_left = 0;
    bit          zero_job = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: floor(acc*scale / 2^Q) clamped to INT8.
    function automatic logic [7:0] ref_byte(input int acc, input int unsigned sc);
        longint p, d, q;
        p = longint'(acc) * longint'(sc);
        d = longint'(1) << SCALE_Q;
        q = p / d;
        if ((p % d) != 0 && p < 0) q = q - 1;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q[7:0];
    endfunction

    task automatic model_job(input int nch, input int accs[$]);
        logic [31:0] w;
        int          n;
        word_t       e;
        w = 32'd0;
        n = 0;
        for (int i = 0; i < accs.size(); i++) begin
            w = w | (32'(ref_byte(accs[i], mdl_tab[i % nch])) << (8 * n));
            n++;
            if (n == 4 || i == accs.size() - 1) begin
                e.data = w;
                e.last = (i == accs.size() - 1);
                exp_q.push_back(e);
                w = 32'd0;
                n = 0;
            end
        end
    endtask

    task automatic write_scale(input int a, input int unsigned v);
        cfg_we    = 1'b1;
        cfg_addr  = 6'(a);
        cfg_scale = 16'(v);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        mdl_tab[a] = v & 32'hFFFF;
    endtask

    // Runs one job; at accumulator index inject_at a stray start and table write are issued.
    task automatic run_job(input int nch, input int npix, input int accs[$], input int inject_at);
        int idx, cyc;
        bit fire, injected, got_done;
        model_job(nch, accs);
        num_ch   = 7'(nch);
        num_pix  = 16'(npix);
        start    = 1'b1;
        zero_job = (nch * npix == 0);
        @(posedge clk); #1;
        start    = 1'b0;
        zero_job = 1'b0;
        idx = 0;
        cyc = 0;
        injected = 1'b0;
        while (idx < accs.size() && cyc < 3000) begin
            bus.acc_valid = ($urandom_range(0, 3) != 0);
            bus.acc_data  = accs[idx];
            if (idx == inject_at && !injected) begin
                injected  = 1'b1;
                start     = 1'b1;
                num_ch    = 7'd1;
                num_pix   = 16'd9;
                cfg_we    = 1'b1;
                cfg_addr  = 6'd0;
                cfg_scale = 16'h1234;
            end
            @(negedge clk);
            fire = bus.acc_valid && bus.acc_ready;
            @(posedge clk); #1;
            start  = 1'b0;
            cfg_we = 1'b0;
            if (fire) idx++;
            cyc++;
        end
        bus.acc_valid = 1'b0;
        check("acc_feed_complete", 32'(idx), 32'(accs.size()));
        got_done = 1'b0;
        for (int k = 0; k < 600 && !got_done; k++) begin
            @(negedge clk);
            if (done) got_done = 1'b1;
        end
        check("job_done_seen", 32'(got_done), 32'd1);
        @(posedge clk); #1;
    endtask

    // Downstream ready generator.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                1: bus.out_ready = ($urandom_range(0, 2) != 0);
                2: begin
                    if (bus.out_valid && bp_left > 0) begin
                        bus.out_ready = 1'b0;
                        bp_left--;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: word scoreboard, done timing, stall stability and backpressure.
    initial begin
        bit          exp_done, stall_v;
        logic [31:0] stall_d;
        logic        stall_l;
        word_t       e;
        exp_done = 1'b0;
        stall_v  = 1'b0;
        stall_d  = 32'd0;
        stall_l  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_done = 1'b0;
                stall_v  = 1'b0;
            end else begin
                if (exp_done || done) check("done_pulse", 32'(done), 32'(exp_done));
                exp_done = (bus.out_valid && bus.out_ready && bus.out_last) || (start && zero_job);
                if (stall_v) begin
                    check("stall_valid", 32'(bus.out_valid), 32'd1);
                    check("stall_data", bus.out_data, stall_d);
                    check("stall_last", 32'(bus.out_last), 32'(stall_l));
                end
                if (bus.out_valid && !bus.out_ready) begin
                    check("bp_acc_ready", 32'(bus.acc_ready), 32'd0);
                    stall_v = 1'b1;
                    stall_d = bus.out_data;
                    stall_l = bus.out_last;
                end else begin
                    stall_v = 1'b0;
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got 0x%08h expected none", bus.out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", bus.out_data, e.data);
                        check("word_last", 32'(bus.out_last), 32'(e.last));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  a[$];
        int  fed;
        bit  fire;
        int  nch, npix;
        bus.acc_valid = 1'b0;
        bus.acc_data  = 32'd0;
        for (int i = 0; i < MAX_CH; i++) mdl_tab[i] = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_acc_ready", 32'(bus.acc_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic pack
        for (int i = 0; i < 4; i++) write_scale(i, 32'h8000);
        a = {100, 20, -3, 1000};
        run_job(4, 1, a, -1);

        // clamp and floor
        write_scale(0, 32'hFFFF);
        a = {32'h7FFFFFFF, 32'h80000000};
        run_job(1, 2, a, -1);
        write_scale(0, 32'h0001);
        a = {-1};
        run_job(1, 1, a, -1);

        // partial word
        for (int i = 0; i < 3; i++) write_scale(i, 32'h4000);
        a = {4, 8, 12, 16, 20, 24};
        run_job(3, 2, a, -1);

        // backpressure, plus stray start and table write during RUN
        for (int i = 0; i < 4; i++) write_scale(i, 32'h8000);
        ready_mode = 2;
        bp_left = 5;
        a = {100, 20, -3, 1000, 7, -500, 300, 64};
        run_job(4, 2, a, 2);
        ready_mode = 0;

        // zero jobs
        a = {};
        run_job(3, 0, a, -1);
        run_job(0, 5, a, -1);

        // reset mid-job
        num_ch  = 7'd4;
        num_pix = 16'd1;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.acc_valid = 1'b1;
        fed = 0;
        for (int k = 0; k < 50 && fed < 2; k++) begin
            bus.acc_data = 10 * (fed + 1);
            @(negedge clk);
            fire = bus.acc_valid && bus.acc_ready;
            @(posedge clk); #1;
            if (fire) fed++;
        end
        bus.acc_valid = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < MAX_CH; i++) mdl_tab[i] = 0;
        @(negedge clk);
        check("mid_rst_acc_ready", 32'(bus.acc_ready), 32'd0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_data", bus.out_data, 32'd0);
        check("mid_rst_out_last", 32'(bus.out_last), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        a = {1000, -1000, 77, 5};
        run_job(2, 2, a, -1);
        for (int i = 0; i < 4; i++) write_scale(i, 32'h8000);
        a = {100, 20, -3, 1000};
        run_job(4, 1, a, -1);

        // randomized jobs with random downstream stalls
        ready_mode = 1;
        for (int j = 0; j < 12; j++) begin
            nch  = $urandom_range(1, 6);
            npix = $urandom_range(1, 4);
            for (int c = 0; c < nch; c++) write_scale(c, $urandom_range(0, 65535));
            a = {};
            for (int i = 0; i < nch * npix; i++) begin
                if ($urandom_range(0, 3) == 0) a.push_back(int'($urandom));
                else a.push_back(int'($urandom_range(0, 4000)) - 2000);
            end
            run_job(nch, npix, a, (j % 3 == 0) ? 1 : -1);
        end
        ready_mode = 0;
        repeat (3) @(posedge clk);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
